systolic_ctrl: RTL

//  Sequencer for an N x N output-stationary systolic array of mac_cell.
//  - Buffers matrix A (row-wise) and matrix B (column-wise) through a valid/ready load port.
//  - Clears the cell accumulators, then drives the skewed A stream into the left edge and the skewed B stream into the top edge.
//  - Flags when all data_mac outputs hold C = A*B; the array itself is read directly by the consumer.

---
 rtl/systolic_pkg.sv | 30 +++
 rtl/mac_cell.sv | 32 +++
 rtl/systolic_skew_feed.sv | 52 +++++
 rtl/systolic_ctrl.sv | 118 +++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared constants and types for the systolic array sequencer.
// Holds default geometry, the feed-length and step-width helpers, and the FSM state type.
// Pure declarations; no logic.
package systolic_pkg;

  localparam int DEFAULT_N      = 4;
  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_ACC_W  = 16;

  // FEED lasts 3N-2 cycles: the last operand pair reaches cell (N-1,N-1) at step 3N-3.
  function automatic int calc_feed_len(input int n);
    return 3 * n - 2;
  endfunction

  // Step counter must hold 0 .. 3N-3.
  function automatic int calc_step_w(input int n);
    return $clog2(3 * n - 1);
  endfunction

  localparam int DEFAULT_FEED_LEN = calc_feed_len(DEFAULT_N);
  localparam int DEFAULT_STEP_W   = calc_step_w(DEFAULT_N);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    FEED  = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/mac_cell.sv
// Output-stationary multiply-accumulate cell: acc += a*b, operands forwarded right/down.
// Latency: operands forwarded one cycle later; accumulator updates every cycle.
// No backpressure; synchronous clear via rst.
module mac_cell
  import systolic_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ACC_W  = DEFAULT_ACC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] datain_a,
  input  logic [DATA_W-1:0] datain_b,
  output logic [DATA_W-1:0] dataout_a,
  output logic [DATA_W-1:0] dataout_b,
  output logic [ACC_W-1:0]  data_mac
);

  // Accumulate the product (wrapping at ACC_W) and pass operands to the neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_mac  <= '0;
      dataout_a <= '0;
      dataout_b <= '0;
    end else begin
      data_mac  <= data_mac + ACC_W'(datain_a) * ACC_W'(datain_b);
      dataout_a <= datain_a;
      dataout_b <= datain_b;
    end
  end

endmodule

// File: rtl/systolic_skew_feed.sv
// Operand buffers for A (by row) and B (by column) plus the skewed edge muxes.
// Latency: writes land next cycle; edge outputs are combinational on step.
// No backpressure; writes are qualified by the controller.
module systolic_skew_feed
  import systolic_pkg::*;
#(
  parameter int N         = DEFAULT_N,
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int CNT_W     = $clog2(N + 1),
  parameter int STEP_BITS = calc_step_w(N)
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [CNT_W-1:0]     wr_idx,
  input  logic [N*DATA_W-1:0]  wr_a_row,
  input  logic [N*DATA_W-1:0]  wr_b_col,
  input  logic                 feed_en,
  input  logic [STEP_BITS-1:0] step,
  output logic [N*DATA_W-1:0]  a_edge,
  output logic [N*DATA_W-1:0]  b_edge
);

  // a_mem[r][k] = A[r][k]; b_mem[c][k] = B[k][c]. Index is [beat][element].
  // Not reset: a reset only clears the beat counter, the stale contents are harmless.
  logic [N-1:0][N-1:0][DATA_W-1:0] a_mem;
  logic [N-1:0][N-1:0][DATA_W-1:0] b_mem;

  // Store one A row and one B column per accepted load beat.
  always_ff @(posedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (wr_en && (wr_idx == CNT_W'(k))) begin
        a_mem[k] <= wr_a_row;
        b_mem[k] <= wr_b_col;
      end
    end
  end

  // Edge slot i carries element k of its row/column when step == i+k (skew by i), else 0.
  always_comb begin
    a_edge = '0;
    b_edge = '0;
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < N; k++) begin
        if (feed_en && (step == STEP_BITS'(i + k))) begin
          a_edge[i*DATA_W +: DATA_W] = a_mem[i][k];
          b_edge[i*DATA_W +: DATA_W] = b_mem[i][k];
        end
      end
    end
  end

endmodule

// File: rtl/systolic_ctrl.sv
// Sequencer for an N x N output-stationary systolic array: load, clear, skewed feed, done.
// Latency: result_valid rises 3N-1 cycles after the edge that samples start.
// Load port stalls (ld_ready=0) once N beats are held and outside IDLE; result held until result_ack.
module systolic_ctrl
  import systolic_pkg::*;
#(
  parameter int N      = DEFAULT_N,
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ld_valid,
  output logic                ld_ready,
  input  logic [N*DATA_W-1:0] ld_a_row,
  input  logic [N*DATA_W-1:0] ld_b_col,
  input  logic                start,
  output logic                busy,
  output logic                result_valid,
  input  logic                result_ack,
  output logic                array_rst,
  output logic [N*DATA_W-1:0] a_edge,
  output logic [N*DATA_W-1:0] b_edge
);

  localparam int CNT_W     = $clog2(N + 1);
  localparam int STEP_BITS = calc_step_w(N);
  localparam int FEED_LEN  = calc_feed_len(N);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;
  logic [STEP_BITS-1:0] step_q, step_d;
  logic                 ld_fire;
  logic                 feed_en;

  // State and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      step_q     <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      step_q     <= step_d;
    end
  end

  // Next-state logic and registered-state output decode.
  always_comb begin
    state_d      = state_q;
    beat_cnt_d   = beat_cnt_q;
    step_d       = step_q;
    ld_ready     = 1'b0;
    busy         = 1'b0;
    result_valid = 1'b0;
    feed_en      = 1'b0;
    array_rst    = rst;
    ld_fire      = 1'b0;

    case (state_q)
      IDLE: begin
        ld_ready = (beat_cnt_q < CNT_W'(N));
        ld_fire  = ld_valid && ld_ready;
        if (ld_fire) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
        // beat_cnt is sampled before this cycle's beat, so a start on the final beat is dropped.
        if (start && (beat_cnt_q == CNT_W'(N))) begin
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        busy      = 1'b1;
        array_rst = 1'b1;
        step_d    = '0;
        state_d   = FEED;
      end
      FEED: begin
        busy    = 1'b1;
        feed_en = 1'b1;
        if (step_q == STEP_BITS'(FEED_LEN - 1)) begin
          step_d  = '0;
          state_d = DONE;
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      DONE: begin
        result_valid = 1'b1;
        if (result_ack) begin
          beat_cnt_d = '0;
          state_d    = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  systolic_skew_feed #(
    .N        (N),
    .DATA_W   (DATA_W),
    .CNT_W    (CNT_W),
    .STEP_BITS(STEP_BITS)
  ) u_feed (
    .clk     (clk),
    .wr_en   (ld_fire),
    .wr_idx  (beat_cnt_q),
    .wr_a_row(ld_a_row),
    .wr_b_col(ld_b_col),
    .feed_en (feed_en),
    .step    (step_q),
    .a_edge  (a_edge),
    .b_edge  (b_edge)
  );

endmodule
